// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the master block.
// Holds response codes, the PROT default and the FSM state type.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_e;

endpackage

// File: rtl/axil_master_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
// Widths follow the ADDR_WIDTH/DATA_WIDTH parameters.
interface axil_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [2:0]            AWPROT;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0] WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [2:0]            ARPROT;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );

endinterface

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite master: cmd/rsp in, AW/W/B/AR/R out.
// Option AXIL_MASTER_ALIGN_CHK_EN: misaligned cmds answer SLVERR, no bus.
module axil_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    axil_master_if.master         axi
);

    state_e                state_q, state_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;
    logic                  misaligned;

`ifdef AXIL_MASTER_ALIGN_CHK_EN
    assign misaligned =
        (cmd_addr & ADDR_WIDTH'(STRB_WIDTH - 1)) != '0;
`else
    assign misaligned = 1'b0;
`endif

    // Next-state and next-output logic for the transaction FSM
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    rdata_d = '0;
                    resp_d  = RESP_OKAY;
                    if (misaligned) begin
                        resp_d      = RESP_SLVERR;
                        rsp_valid_d = 1'b1;
                        state_d     = RSP;
                    end else if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // a low VALID here means that channel already handshook
                if (awvalid_q && axi.AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && axi.WREADY) wvalid_d = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi.BVALID) begin
                    bready_d    = 1'b0;
                    resp_d      = axi.BRESP;
                    rdata_d     = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RD_REQ: begin
                if (axi.ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (axi.RVALID) begin
                    rready_d    = 1'b0;
                    rdata_d     = axi.RDATA;
                    resp_d      = axi.RRESP;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset drops any in-flight transfer
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
        end
    end

    // Ready is held off while reset is asserted
    assign cmd_ready   = (state_q == IDLE) && !ARESET;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = write_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;

    assign axi.AWADDR  = addr_q;
    assign axi.AWPROT  = PROT_DEFAULT;
    assign axi.AWVALID = awvalid_q;
    assign axi.WDATA   = wdata_q;
    assign axi.WSTRB   = wstrb_q;
    assign axi.WVALID  = wvalid_q;
    assign axi.BREADY  = bready_q;
    assign axi.ARADDR  = addr_q;
    assign axi.ARPROT  = PROT_DEFAULT;
    assign axi.ARVALID = arvalid_q;
    assign axi.RREADY  = rready_q;

endmodule

// File: tb/tb_axil_master.sv
// Self-checking bench for axil_master with a delay-programmable slave.
// Build with AXIL_MASTER_ALIGN_CHK_EN to exercise the alignment check.
module tb_axil_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;

    axil_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axil_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .axi       (axi)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    bit aw_hs = 0, w_hs = 0, ar_hs = 0;
    bit auto_slv = 1;
    bit a_awready = 0, a_wready = 0, a_arready = 0;
    bit a_bvalid = 0, a_rvalid = 0;
    bit m_awready = 0, m_wready = 0, m_arready = 0;
    bit m_bvalid = 0, m_rvalid = 0;
    logic [1:0]    s_bresp = 2'b00;
    logic [1:0]    s_rresp = 2'b00;
    logic [DW-1:0] s_rdata = '0;

    assign axi.AWREADY = auto_slv ? a_awready : m_awready;
    assign axi.WREADY  = auto_slv ? a_wready  : m_wready;
    assign axi.ARREADY = auto_slv ? a_arready : m_arready;
    assign axi.BVALID  = auto_slv ? a_bvalid  : m_bvalid;
    assign axi.RVALID  = auto_slv ? a_rvalid  : m_rvalid;
    assign axi.BRESP   = s_bresp;
    assign axi.RRESP   = s_rresp;
    assign axi.RDATA   = s_rdata;

    always @(negedge ACLK) begin
        if (axi.AWVALID) begin
            a_awready = (aw_cnt >= aw_dly); aw_cnt++;
        end else begin
            a_awready = 0; aw_cnt = 0;
        end
        if (axi.WVALID) begin
            a_wready = (w_cnt >= w_dly); w_cnt++;
        end else begin
            a_wready = 0; w_cnt = 0;
        end
        if (axi.ARVALID) begin
            a_arready = (ar_cnt >= ar_dly); ar_cnt++;
        end else begin
            a_arready = 0; ar_cnt = 0;
        end
        if (aw_hs && w_hs) begin
            a_bvalid = (b_cnt >= b_dly); b_cnt++;
        end else begin
            a_bvalid = 0; b_cnt = 0;
        end
        if (ar_hs) begin
            a_rvalid = (r_cnt >= r_dly); r_cnt++;
        end else begin
            a_rvalid = 0; r_cnt = 0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    typedef struct {
        logic          write;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   acc_q[$];
    int   cyc = 0, acc_cyc = 0;
    int   n_acc = 0, n_rsp = 0, n_aw = 0, n_w = 0, n_ar = 0;
    logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
    logic [DW-1:0] last_wdata = '0;
    logic [SW-1:0] last_wstrb = '0;

    bit p_rst = 1;
    bit p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    bit p_rspv = 0, p_rspr = 0;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata, p_rdata;
    logic [SW-1:0] p_wstrb;
    logic [1:0]    p_resp;
    logic          p_write;

    always @(posedge ACLK) begin
        cyc++;
        if (!auto_slv) begin
            aw_hs = 0; w_hs = 0; ar_hs = 0;
        end else begin
            if (axi.AWVALID && axi.AWREADY) aw_hs = 1;
            if (axi.WVALID && axi.WREADY) w_hs = 1;
            if (axi.ARVALID && axi.ARREADY) ar_hs = 1;
            if (axi.BVALID && axi.BREADY) begin
                aw_hs = 0; w_hs = 0;
            end
            if (axi.RVALID && axi.RREADY) ar_hs = 0;
        end
        if (axi.AWVALID && axi.AWREADY) begin
            n_aw++; last_awaddr = axi.AWADDR;
        end
        if (axi.WVALID && axi.WREADY) begin
            n_w++; last_wdata = axi.WDATA; last_wstrb = axi.WSTRB;
        end
        if (axi.ARVALID && axi.ARREADY) begin
            n_ar++; last_araddr = axi.ARADDR;
        end
        if (cmd_valid && cmd_ready) begin
            n_acc++; acc_cyc = cyc; acc_q.push_back(cyc);
        end
        if (rsp_valid === 1'b1 && rsp_ready) begin
            n_rsp++;
            if (sb.size() == 0) begin
                chk("rsp_unexpected", n_rsp, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_write", rsp_write, e.write);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_resp", rsp_resp, e.resp);
            end
        end
        if (!p_rst && p_awv && !p_awr) begin
            chk("aw_hold", axi.AWVALID, 1);
            chk("aw_addr_stable", axi.AWADDR, p_awaddr);
        end
        if (!p_rst && p_wv && !p_wr) begin
            chk("w_hold", axi.WVALID, 1);
            chk("w_data_stable", axi.WDATA, p_wdata);
            chk("w_strb_stable", axi.WSTRB, p_wstrb);
        end
        if (!p_rst && p_arv && !p_arr) begin
            chk("ar_hold", axi.ARVALID, 1);
            chk("ar_addr_stable", axi.ARADDR, p_araddr);
        end
        if (!p_rst && p_rspv && !p_rspr) begin
            chk("rsp_hold", rsp_valid, 1);
            chk("rsp_rdata_stable", rsp_rdata, p_rdata);
            chk("rsp_resp_stable", rsp_resp, p_resp);
            chk("rsp_write_stable", rsp_write, p_write);
        end
        if (axi.BREADY === 1'b1)
            chk("bready_order", axi.AWVALID | axi.WVALID, 0);
        if (axi.RREADY === 1'b1)
            chk("rready_order", axi.ARVALID, 0);
        if (axi.AWVALID === 1'b1)
            chk("awprot", axi.AWPROT, 3'b000);
        if (axi.ARVALID === 1'b1)
            chk("arprot", axi.ARPROT, 3'b000);
        p_rst    = ARESET;
        p_awv    = axi.AWVALID === 1'b1;
        p_awr    = axi.AWREADY;
        p_wv     = axi.WVALID === 1'b1;
        p_wr     = axi.WREADY;
        p_arv    = axi.ARVALID === 1'b1;
        p_arr    = axi.ARREADY;
        p_rspv   = rsp_valid === 1'b1;
        p_rspr   = rsp_ready;
        p_awaddr = axi.AWADDR;
        p_araddr = axi.ARADDR;
        p_wdata  = axi.WDATA;
        p_wstrb  = axi.WSTRB;
        p_rdata  = rsp_rdata;
        p_resp   = rsp_resp;
        p_write  = rsp_write;
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        int            awd;
        int            wd;
        int            ard;
        int            bd;
        int            rd;
        logic [1:0]    resp;
        int            hold;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v);
        bit mis;
        bit seen;
        int exp_lat;
        int acc0, aw0, w0, ar0;
        exp_t x;
        mis = 0;
`ifdef AXIL_MASTER_ALIGN_CHK_EN
        mis = (v.addr[1:0] != 2'b00);
`endif
        aw_dly = v.awd; w_dly = v.wd; ar_dly = v.ard;
        b_dly = v.bd; r_dly = v.rd;
        s_bresp = v.resp; s_rresp = v.resp; s_rdata = v.data;
        if (mis) exp_lat = 0;
        else if (v.write)
            exp_lat = 2 + ((v.awd > v.wd) ? v.awd : v.wd) + v.bd;
        else exp_lat = 2 + v.ard + v.rd;
        x.write = v.write;
        x.rdata = (v.write || mis) ? '0 : v.data;
        x.resp  = mis ? 2'b10 : v.resp;
        sb.push_back(x);
        aw0 = n_aw; w0 = n_w; ar0 = n_ar;
        @(negedge ACLK);
        cmd_valid = 1; cmd_write = v.write; cmd_addr = v.addr;
        cmd_wdata = v.write ? v.data : '0; cmd_wstrb = v.strb;
        acc0 = n_acc;
        for (int i = 0; i < 50 && n_acc == acc0; i++) @(negedge ACLK);
        cmd_valid = 0;
        chk("cmd_accept", n_acc - acc0, 1);
        if (n_acc == acc0) return;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) begin
                seen = 1;
                break;
            end
            @(negedge ACLK);
        end
        chk("rsp_seen", seen, 1);
        if (!seen) return;
        chk("latency", cyc - acc_cyc, exp_lat);
        acc0 = n_acc;
        for (int i = 0; i < v.hold; i++) begin
            chk("hold_cmd_ready", cmd_ready, 0);
            cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h40;
            @(negedge ACLK);
        end
        cmd_valid = 0;
        rsp_ready = 1;
        @(negedge ACLK);
        rsp_ready = 0;
        chk("rsp_drop", rsp_valid, 0);
        chk("no_sneak_accept", n_acc, acc0);
        if (mis) begin
            chk("no_bus", (n_aw - aw0) + (n_w - w0) + (n_ar - ar0), 0);
        end else if (v.write) begin
            chk("aw_count", n_aw - aw0, 1);
            chk("w_count", n_w - w0, 1);
            chk("awaddr", last_awaddr, v.addr);
            chk("wdata", last_wdata, v.data);
            chk("wstrb", last_wstrb, v.strb);
        end else begin
            chk("ar_count", n_ar - ar0, 1);
            chk("araddr", last_araddr, v.addr);
        end
    endtask

    initial begin
        int acc0, rsp0;
        exp_t x;
        vecs[0] = '{1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0};
        vecs[1] = '{0, 32'h10, 32'hDEADBEEF, 4'h0, 0, 0, 3, 0, 2, 2'b00, 0};
        vecs[2] = '{1, 32'h24, 32'h01234567, 4'hF, 4, 0, 0, 0, 0, 2'b00, 0};
        vecs[3] = '{0, 32'h30, 32'h89ABCDEF, 4'h0, 0, 0, 1, 0, 1, 2'b10, 5};
        vecs[4] = '{1, 32'h34, 32'h5555AAAA, 4'h3, 0, 2, 0, 3, 0, 2'b11, 0};
        vecs[5] = '{0, 32'h13, 32'h13131313, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0};
        vecs[6] = '{1, 32'h06, 32'hA5A5A5A5, 4'hC, 1, 1, 0, 0, 0, 2'b01, 0};
        vecs[7] = '{0, 32'hFFFFFFFC, 32'hFFFFFFFF, 4'h0,
                    0, 0, 0, 0, 0, 2'b01, 2};

        ARESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 0;
        repeat (2) @(negedge ACLK);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_resp", rsp_resp, 0);
        chk("rst_awvalid", axi.AWVALID, 0);
        chk("rst_wvalid", axi.WVALID, 0);
        chk("rst_arvalid", axi.ARVALID, 0);
        chk("rst_bready", axi.BREADY, 0);
        chk("rst_rready", axi.RREADY, 0);
        ARESET = 0;
        #1;
        chk("rst_release_ready", cmd_ready, 1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // reset while waiting on R, then stray R/B must be ignored
        auto_slv = 0;
        s_rdata = 32'hCAFE0001; s_rresp = 2'b00; s_bresp = 2'b00;
        @(negedge ACLK);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h18;
        acc0 = n_acc;
        @(negedge ACLK);
        cmd_valid = 0;
        chk("rst_seq_accept", n_acc - acc0, 1);
        chk("rst_seq_arvalid", axi.ARVALID, 1);
        m_arready = 1;
        @(negedge ACLK);
        m_arready = 0;
        chk("rst_seq_rready", axi.RREADY, 1);
        ARESET = 1;
        @(negedge ACLK);
        chk("mid_rst_arvalid", axi.ARVALID, 0);
        chk("mid_rst_rready", axi.RREADY, 0);
        chk("mid_rst_awvalid", axi.AWVALID, 0);
        chk("mid_rst_wvalid", axi.WVALID, 0);
        chk("mid_rst_bready", axi.BREADY, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rdata", rsp_rdata, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        ARESET = 0;
        m_rvalid = 1; m_bvalid = 1; s_rdata = 32'hBAD0BAD0;
        rsp0 = n_rsp;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("stray_rsp_valid", rsp_valid, 0);
            chk("stray_rready", axi.RREADY, 0);
            chk("stray_bready", axi.BREADY, 0);
            chk("stray_cmd_ready", cmd_ready, 1);
        end
        m_rvalid = 0; m_bvalid = 0;
        chk("stray_no_rsp", n_rsp, rsp0);
        auto_slv = 1;
        run_vec('{0, 32'h18, 32'h600DF00D, 4'h0,
                  0, 0, 1, 0, 1, 2'b00, 0});

        // back-to-back reads with rsp_ready held high
        aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;
        s_rdata = 32'h0BADF00D; s_rresp = 2'b00;
        x.write = 0; x.rdata = 32'h0BADF00D; x.resp = 2'b00;
        repeat (3) sb.push_back(x);
        @(negedge ACLK);
        acc_q.delete();
        acc0 = n_acc; rsp0 = n_rsp;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20; rsp_ready = 1;
        for (int i = 0; i < 60 && n_acc - acc0 < 3; i++) @(negedge ACLK);
        cmd_valid = 0;
        for (int i = 0; i < 60 && n_rsp - rsp0 < 3; i++) @(negedge ACLK);
        rsp_ready = 0;
        chk("b2b_accepts", n_acc - acc0, 3);
        chk("b2b_rsps", n_rsp - rsp0, 3);
        if (acc_q.size() == 3) begin
            chk("b2b_gap1", acc_q[1] - acc_q[0], 4);
            chk("b2b_gap2", acc_q[2] - acc_q[1], 4);
        end else begin
            chk("b2b_acc_q", acc_q.size(), 3);
        end

        repeat (3) @(negedge ACLK);
        chk("sb_empty", sb.size(), 0);
        chk("final_idle", cmd_ready, 1);
        chk("final_rsp_valid", rsp_valid, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
